// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, widths and decode helpers for the keypad encoder
package keypad_pkg;

  localparam int KEY_W = 10;
  localparam int BCD_W = 4;
  localparam int ENTRY_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    REJECT = 2'd2,
    LOCK   = 2'd3
  } state_e;

  // OR of the indices of all set bits; exact for a one-hot input.
  function automatic logic [BCD_W-1:0] onehot_to_bin(input logic [KEY_W-1:0] x);
    logic [BCD_W-1:0] b;
    b = '0;
    for (int i = 0; i < KEY_W; i++) begin
      if (x[i]) b = b | BCD_W'(i);
    end
    return b;
  endfunction

  function automatic logic more_than_one(input logic [KEY_W-1:0] x);
    return (x & (x - KEY_W'(1))) != '0;
  endfunction

endpackage

// File: rtl/keypad_onehot_enc.sv
// rtl/keypad_onehot_enc.sv - combinational key-line decode into digit code, any-key and multi-key flags
module keypad_onehot_enc
  import keypad_pkg::*;
(
  input  logic [KEY_W-1:0] keys_i,
  output logic [BCD_W-1:0] code_o,
  output logic             any_o,
  output logic             multi_o
);

  always_comb begin
    code_o  = onehot_to_bin(keys_i);
    any_o   = |keys_i;
    multi_o = more_than_one(keys_i);
  end

endmodule

// File: rtl/keypad_encoder.sv
// rtl/keypad_encoder.sv - press/reject/lockout FSM feeding a BCD MM:SS entry shift buffer
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int NKEYS          = 10,
  parameter int DIGITS         = 4,
  parameter int RELEASE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NKEYS-1:0]      keys,
  input  logic                  clr_entry,
  output logic [3:0]            key_code,
  output logic                  key_valid,
  output logic                  multi_err,
  output logic [4*DIGITS-1:0]   entry,
  output logic [2:0]            entry_cnt
);

  localparam int CNT_W = $clog2(RELEASE_CYCLES + 1);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_CYCLES - 1);
  localparam logic [ENTRY_CNT_W-1:0] CNT_FULL = ENTRY_CNT_W'(DIGITS);

  logic [NKEYS-1:0]       keys_q;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       rel_cnt_q, rel_cnt_d;
  logic [BCD_W-1:0]       key_code_q, key_code_d;
  logic [4*DIGITS-1:0]    entry_q, entry_d;
  logic [ENTRY_CNT_W-1:0] entry_cnt_q, entry_cnt_d;

  logic [BCD_W-1:0] enc_code;
  logic             enc_any;
  logic             enc_multi;

  keypad_onehot_enc u_enc (
    .keys_i  (keys_q),
    .code_o  (enc_code),
    .any_o   (enc_any),
    .multi_o (enc_multi)
  );

  // Reset lands in LOCK so a key held across reset must be released before it counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys_q      <= '0;
      state_q     <= LOCK;
      rel_cnt_q   <= '0;
      key_code_q  <= '0;
      entry_q     <= '0;
      entry_cnt_q <= '0;
    end else begin
      keys_q      <= keys;
      state_q     <= state_d;
      rel_cnt_q   <= rel_cnt_d;
      key_code_q  <= key_code_d;
      entry_q     <= entry_d;
      entry_cnt_q <= entry_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rel_cnt_d  = '0;
    key_code_d = key_code_q;
    case (state_q)
      IDLE: begin
        if (enc_any) begin
          if (enc_multi) begin
            state_d = REJECT;
          end else begin
            state_d    = ACCEPT;
            key_code_d = enc_code;
          end
        end
      end
      ACCEPT, REJECT: state_d = LOCK;
      LOCK: begin
        // Any activity, including bounce, restarts the clean-release count.
        if (!enc_any) begin
          if (rel_cnt_q == REL_LAST) begin
            state_d = IDLE;
          end else begin
            rel_cnt_d = rel_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = LOCK;
    endcase
  end

  // Clear wins over a coincident accept; a full buffer silently drops digits.
  always_comb begin
    entry_d     = entry_q;
    entry_cnt_d = entry_cnt_q;
    if (clr_entry) begin
      entry_d     = '0;
      entry_cnt_d = '0;
    end else if (state_q == ACCEPT && entry_cnt_q < CNT_FULL) begin
      entry_d     = {entry_q[4*DIGITS-5:0], key_code_q};
      entry_cnt_d = entry_cnt_q + ENTRY_CNT_W'(1);
    end
  end

  assign key_valid = (state_q == ACCEPT);
  assign multi_err = (state_q == REJECT);
  assign key_code  = key_code_q;
  assign entry     = entry_q;
  assign entry_cnt = entry_cnt_q;

  a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(key_valid && multi_err));
  a_valid_single: assert property (@(posedge clk) disable iff (!rst_n)
    key_valid |=> !key_valid);
  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
    entry_cnt <= CNT_FULL);

endmodule

// File: tb/tb_keypad_encoder.sv
// tb/tb_keypad_encoder.sv - scoreboard bench with a sample-window reference model for keypad_encoder
module tb_keypad_encoder;

  localparam int RC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  keys = '0;
  logic        clr_entry = 1'b0;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        multi_err;
  logic [15:0] entry;
  logic [2:0]  entry_cnt;

  keypad_encoder #(.NKEYS(10), .DIGITS(4), .RELEASE_CYCLES(RC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .keys      (keys),
    .clr_entry (clr_entry),
    .key_code  (key_code),
    .key_valid (key_valid),
    .multi_err (multi_err),
    .entry     (entry),
    .entry_cnt (entry_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_multi  = 0;

  typedef struct { logic multi; logic [3:0] code; int cyc; } ev_t;
  typedef struct { logic [15:0] entry; logic [2:0] cnt; } ent_t;
  ev_t  evq[$];
  ent_t entq[$];

  // Reference model: the key stream is kept as a history of samples; a nonzero
  // sample is reported when the RC samples before it are all zero and that
  // window begins at or after the point where lockout began.
  logic [9:0] hist[$];
  int   lock_start;
  int   m_entry;
  int   m_cnt;
  int   last_code;
  bit   pend_valid;
  int   pend_idx;
  bit   pend_multi;
  int   pend_code;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    hist.push_back(10'd0);
    lock_start = 0;
    m_entry    = 0;
    m_cnt      = 0;
    last_code  = 0;
    pend_valid = 0;
  endtask

  task automatic model_step(input logic [9:0] k, input logic c);
    int  idx;
    bit  quiet;
    ev_t e;
    idx = hist.size();
    if (pend_valid && pend_idx == idx) begin
      if (c) begin
        m_entry = 0; m_cnt = 0;
      end else if (!pend_multi && m_cnt < 4) begin
        m_entry = (m_entry * 16 + pend_code) % 65536;
        m_cnt++;
      end
      entq.push_back('{16'(m_entry), 3'(m_cnt)});
      pend_valid = 0;
    end else if (c) begin
      m_entry = 0; m_cnt = 0;
    end
    hist.push_back(k);
    if (k != 0 && idx - RC >= lock_start) begin
      quiet = 1;
      for (int i = idx - RC; i < idx; i++) if (hist[i] != 0) quiet = 0;
      if (quiet) begin
        e.multi = ($countones(k) > 1);
        if (!e.multi) last_code = $clog2(k);
        e.code = 4'(last_code);
        e.cyc  = cyc + 2;
        evq.push_back(e);
        pend_valid = 1;
        pend_idx   = idx + 2;
        pend_multi = e.multi;
        pend_code  = last_code;
        lock_start = idx + 2;
      end
    end
  endtask

  task automatic drive(input logic [9:0] k, input logic c);
    keys = k;
    clr_entry = c;
    model_step(k, c);
    @(negedge clk);
  endtask

  task automatic press(input logic [9:0] m, input int hold, input int rel, input int clr_step);
    for (int i = 0; i < hold; i++) drive(m, i == clr_step);
    for (int i = 0; i < rel; i++) drive('0, 1'b0);
  endtask

  task automatic reset_seq();
    rst_n = 1'b0;
    clr_entry = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_key_code", 32'(key_code), 0);
    chk("rst_strobes", 32'({key_valid, multi_err}), 0);
    chk("rst_entry", 32'(entry), 0);
    chk("rst_entry_cnt", 32'(entry_cnt), 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  bit ent_pending = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (ent_pending) begin
        ent_t x;
        ent_pending = 0;
        if (entq.size() == 0) begin
          chk("entry_queue_empty", 1, 0);
        end else begin
          x = entq.pop_front();
          chk("entry", 32'(entry), 32'(x.entry));
          chk("entry_cnt", 32'(entry_cnt), 32'(x.cnt));
        end
      end
      if (key_valid || multi_err) begin
        ev_t e;
        if (key_valid) n_valid++;
        if (multi_err) n_multi++;
        if (evq.size() == 0) begin
          chk("unexpected_strobe", 32'({key_valid, multi_err}), 0);
        end else begin
          e = evq.pop_front();
          chk("strobe_kind", 32'({key_valid, multi_err}), e.multi ? 32'd1 : 32'd2);
          chk("key_code", 32'(key_code), 32'(e.code));
          chk("latency", 32'(cyc), 32'(e.cyc));
          ent_pending = 1;
        end
      end
    end
  end

  task automatic random_phase(input int iters);
    int r, a, b, hold, rel;
    logic [9:0] m;
    for (int it = 0; it < iters; it++) begin
      r = $urandom_range(0, 99);
      if (r < 78) begin
        m = 10'(1) << $urandom_range(0, 9);
      end else if (r < 95) begin
        a = $urandom_range(0, 9);
        b = (a + $urandom_range(1, 9)) % 10;
        m = (10'(1) << a) | (10'(1) << b) | (10'($urandom) & 10'($urandom));
      end else begin
        m = '0;
      end
      hold = $urandom_range(1, 6);
      for (int j = 0; j < hold; j++) drive(m, $urandom_range(0, 19) == 0);
      rel = $urandom_range(0, 7);
      for (int j = 0; j < rel; j++)
        drive(($urandom_range(0, 9) == 0) ? m : 10'd0, $urandom_range(0, 19) == 0);
    end
  endtask

  int v0, mu0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    #2;
    reset_seq();
    for (int i = 0; i < RC + 2; i++) drive('0, 1'b0);
    chk("idle_strobes", 32'({key_valid, multi_err}), 0);
    chk("idle_entry", 32'(entry), 0);

    v0 = n_valid;
    press(10'b0010000000, 20, 6, -1);
    chk("t1_valid_count", 32'(n_valid - v0), 1);
    chk("t1_key_code", 32'(key_code), 7);
    chk("t1_entry", 32'(entry), 32'h0007);
    chk("t1_entry_cnt", 32'(entry_cnt), 1);

    drive('0, 1'b1);
    for (int i = 0; i < RC; i++) drive('0, 1'b0);
    chk("clr_idle_entry", 32'(entry), 0);
    v0 = n_valid;
    press(10'b0000000010, 3, 6, -1);
    press(10'b0000000100, 3, 6, -1);
    press(10'b0000001000, 3, 6, -1);
    press(10'b0000000001, 3, 6, -1);
    press(10'b0000100000, 3, 6, -1);
    chk("t2_valid_count", 32'(n_valid - v0), 5);
    chk("t2_key_code", 32'(key_code), 5);
    chk("t2_entry", 32'(entry), 32'h1230);
    chk("t2_entry_cnt", 32'(entry_cnt), 4);

    v0 = n_valid; mu0 = n_multi;
    press(10'b0000001001, 3, 0, -1);
    press(10'b0000000100, 3, 6, -1);
    chk("t3_multi_count", 32'(n_multi - mu0), 1);
    chk("t3_valid_count", 32'(n_valid - v0), 0);
    chk("t3_entry", 32'(entry), 32'h1230);
    chk("t3_key_code", 32'(key_code), 5);

    v0 = n_valid;
    press(10'b0000010000, 3, 2, -1);
    press(10'b0000010000, 1, RC - 1, -1);
    press(10'b0100000000, 2, 6, -1);
    chk("t4_bounce_valid_count", 32'(n_valid - v0), 1);
    press(10'b0100000000, 2, 6, -1);
    chk("t4_rearm_valid_count", 32'(n_valid - v0), 2);
    chk("t4_key_code", 32'(key_code), 8);

    press(10'b1000000000, 4, 6, 2);
    chk("t5_clr_key_code", 32'(key_code), 9);
    chk("t5_clr_entry", 32'(entry), 0);
    chk("t5_clr_entry_cnt", 32'(entry_cnt), 0);

    v0 = n_valid;
    press(10'b0000001000, 6, 0, -1);
    keys = 10'b0000001000;
    reset_seq();
    for (int i = 0; i < 10; i++) drive(10'b0000001000, 1'b0);
    chk("t5_held_reset_count", 32'(n_valid - v0), 1);
    for (int i = 0; i < 6; i++) drive('0, 1'b0);
    press(10'b0000001000, 3, 6, -1);
    chk("t5_repress_count", 32'(n_valid - v0), 2);
    chk("t5_repress_entry", 32'(entry), 32'h0003);

    random_phase(300);
    for (int i = 0; i < 8; i++) drive('0, 1'b0);
    chk("end_events_drained", 32'(evq.size()), 0);
    chk("end_entries_drained", 32'(entq.size()), 0);
    chk("end_entry", 32'(entry), 32'(m_entry));
    chk("end_entry_cnt", 32'(entry_cnt), 32'(m_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
